// File: rtl/machine_cycle_sequencer.sv
// T-step / M-cycle timing generator for the CPU control unit (FETCH -> RUN -> HALT).
// Latency: count and state update on the clock after an M-cycle boundary; o_M_Boundary is combinational.
// Backpressure: i_Stall high freezes step, state, count and error; no boundary is signalled while stalled.
module machine_cycle_sequencer #(
    parameter int COUNT_WIDTH = 8,
    parameter int STEP_WIDTH  = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Stall,
    input  logic                   i_IR_Fetch,
    input  logic                   i_Halt_Req,
    input  logic                   i_Wake,
    output logic [STEP_WIDTH-1:0]  o_Cycle_Step,
    output logic [COUNT_WIDTH-1:0] o_Cycle_Count,
    output logic                   o_Active,
    output logic                   o_Force_Fetch,
    output logic                   o_Halted,
    output logic                   o_M_Boundary,
    output logic                   o_Seq_Error
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   err_q, err_d;
    logic                   m_boundary;

    assign m_boundary = step_q[STEP_WIDTH-1] & ~i_Stall;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_FETCH;
            step_q  <= STEP_WIDTH'(1);
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        err_d   = err_q;
        if (!i_Stall) begin
            step_d = {step_q[STEP_WIDTH-2:0], step_q[STEP_WIDTH-1]};
        end
        // Control inputs only matter on the clock that closes an M-cycle.
        if (m_boundary) begin
            unique case (state_q)
                ST_FETCH: begin
                    state_d = ST_RUN;
                    count_d = COUNT_WIDTH'(1);
                end
                ST_RUN: begin
                    if (i_Halt_Req) begin
                        state_d = ST_HALT;
                        count_d = '0;
                    end else if (i_IR_Fetch) begin
                        count_d = COUNT_WIDTH'(1);
                    end else if (count_q[COUNT_WIDTH-1]) begin
                        count_d = COUNT_WIDTH'(1);
                        err_d   = 1'b1;
                    end else begin
                        count_d = {count_q[COUNT_WIDTH-2:0], 1'b0};
                    end
                end
                ST_HALT: begin
                    if (i_Wake) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    count_d = '0;
                end
            endcase
        end
    end

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_Active      = (state_q == ST_RUN);
    assign o_Force_Fetch = (state_q == ST_FETCH);
    assign o_Halted      = (state_q == ST_HALT);
    assign o_M_Boundary  = m_boundary;
    assign o_Seq_Error   = err_q;

endmodule

// File: tb/tb_machine_cycle_sequencer.sv
// Directed bench for machine_cycle_sequencer; expected outputs are queued per clock and checked by a monitor.
module tb_machine_cycle_sequencer;

    localparam int ST_F = 0;
    localparam int ST_R = 1;
    localparam int ST_H = 2;

    typedef struct {
        logic [3:0] step;
        logic [7:0] cnt;
        logic       act;
        logic       ff;
        logic       hlt;
        logic       bnd;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       fetch = 1'b0;
    logic       halt = 1'b0;
    logic       wake = 1'b0;
    logic [3:0] step_o;
    logic [7:0] cnt_o;
    logic       act_o, ff_o, hlt_o, bnd_o, err_o;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    machine_cycle_sequencer #(.COUNT_WIDTH(8), .STEP_WIDTH(4)) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Stall       (stall),
        .i_IR_Fetch    (fetch),
        .i_Halt_Req    (halt),
        .i_Wake        (wake),
        .o_Cycle_Step  (step_o),
        .o_Cycle_Count (cnt_o),
        .o_Active      (act_o),
        .o_Force_Fetch (ff_o),
        .o_Halted      (hlt_o),
        .o_M_Boundary  (bnd_o),
        .o_Seq_Error   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are sampled just after inputs for the cycle are applied.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("step",  {4'b0, step_o}, {4'b0, e.step});
                chk("count", cnt_o, e.cnt);
                chk("active", {7'b0, act_o}, {7'b0, e.act});
                chk("force_fetch", {7'b0, ff_o}, {7'b0, e.ff});
                chk("halted", {7'b0, hlt_o}, {7'b0, e.hlt});
                chk("boundary", {7'b0, bnd_o}, {7'b0, e.bnd});
                chk("seq_error", {7'b0, err_o}, {7'b0, e.err});
            end
        end
    end

    // Apply one clock of inputs and queue the outputs expected while they are applied.
    task automatic cyc(input logic r, input logic s, input logic f, input logic h, input logic w,
                       input logic [3:0] es, input logic [7:0] ec, input int st,
                       input logic eb, input logic ee);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; fetch = f; halt = h; wake = w;
        e.step = es;
        e.cnt  = ec;
        e.act  = (st == ST_R);
        e.ff   = (st == ST_F);
        e.hlt  = (st == ST_H);
        e.bnd  = eb;
        e.err  = ee;
        exp_q.push_back(e);
    endtask

    // One unstalled M-cycle; f/h/w are held for all four steps.
    task automatic mcyc(input logic f, input logic h, input logic w,
                        input logic [7:0] ec, input int st, input logic ee);
        cyc(0, 0, f, h, w, 4'b0001, ec, st, 0, ee);
        cyc(0, 0, f, h, w, 4'b0010, ec, st, 0, ee);
        cyc(0, 0, f, h, w, 4'b0100, ec, st, 0, ee);
        cyc(0, 0, f, h, w, 4'b1000, ec, st, 1, ee);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset release: FETCH for four steps, then RUN with count 01.
        mcyc(0, 0, 0, 8'h00, ST_F, 0);

        // Three-cycle instruction, fetch requested only during count 04.
        mcyc(0, 0, 0, 8'h01, ST_R, 0);
        mcyc(0, 0, 0, 8'h02, ST_R, 0);
        mcyc(1, 0, 0, 8'h04, ST_R, 0);

        // Two-cycle instruction with a 3-clock stall in step 0100.
        mcyc(0, 0, 0, 8'h01, ST_R, 0);
        cyc(0, 0, 1, 0, 0, 4'b0001, 8'h02, ST_R, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'b0010, 8'h02, ST_R, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'b0100, 8'h02, ST_R, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'b0100, 8'h02, ST_R, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'b0100, 8'h02, ST_R, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'b0100, 8'h02, ST_R, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'b1000, 8'h02, ST_R, 1, 0);

        // Halt beats fetch; a wake pulse off the boundary is ignored.
        cyc(0, 0, 0, 0, 0, 4'b0001, 8'h01, ST_R, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b0010, 8'h01, ST_R, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b0100, 8'h01, ST_R, 0, 0);
        cyc(0, 0, 1, 1, 0, 4'b1000, 8'h01, ST_R, 1, 0);
        cyc(0, 0, 0, 0, 0, 4'b0001, 8'h00, ST_H, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'b0010, 8'h00, ST_H, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b0100, 8'h00, ST_H, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b1000, 8'h00, ST_H, 1, 0);
        mcyc(0, 0, 1, 8'h00, ST_H, 0);
        mcyc(0, 0, 0, 8'h00, ST_F, 0);

        // Eight M-cycles without fetch: wrap sets the sticky error.
        for (int m = 0; m < 8; m++) begin
            mcyc(0, 0, 0, 8'h01 << m, ST_R, 0);
        end
        mcyc(0, 0, 0, 8'h01, ST_R, 1);
        mcyc(0, 0, 0, 8'h02, ST_R, 1);
        mcyc(0, 0, 0, 8'h04, ST_R, 1);

        // Reset mid-instruction while stalled wins over the stall.
        cyc(0, 0, 0, 0, 0, 4'b0001, 8'h08, ST_R, 0, 1);
        cyc(0, 0, 0, 0, 0, 4'b0010, 8'h08, ST_R, 0, 1);
        cyc(1, 1, 0, 0, 0, 4'b0100, 8'h08, ST_R, 0, 1);
        cyc(0, 0, 0, 0, 0, 4'b0001, 8'h00, ST_F, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b0010, 8'h00, ST_F, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b0100, 8'h00, ST_F, 0, 0);

        // A stall on step 1000 suppresses the boundary until it drops.
        cyc(0, 1, 0, 0, 0, 4'b1000, 8'h00, ST_F, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'b1000, 8'h00, ST_F, 1, 0);
        cyc(0, 0, 0, 0, 0, 4'b0001, 8'h01, ST_R, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/machine_cycle_sequencer.md
Name: machine_cycle_sequencer

Overview:
Generates the T-step and M-cycle timing that drives every per-opcode microcode unit in the CPU control unit. Outputs a one-hot T-step (4 per M-cycle) and a one-hot M-cycle count, restarted whenever the active microcode requests an opcode fetch. Owns the forced opcode fetch after reset or wake, the HALT idle state, and bus-stall freezing. Sits between the control-unit top level and the microcode decoders; their o_IR_Fetch outputs are OR-reduced into i_IR_Fetch.

Parameters:
COUNT_WIDTH, 8, width of one-hot M-cycle count; max instruction length in M-cycles.
STEP_WIDTH, 4, width of one-hot T-step; T-states per M-cycle.

Ports:
i_Clk  input  1  system clock; all state updates on rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Stall  input  1  memory/bus wait; freezes all sequencer state while high.
i_IR_Fetch  input  1  OR of microcode fetch requests; the current M-cycle is the next opcode fetch.
i_Halt_Req  input  1  HALT microcode request; enter HALT at the M-cycle boundary.
i_Wake  input  1  interrupt pending; leave HALT.
o_Cycle_Step  output  STEP_WIDTH  one-hot T-step.
o_Cycle_Count  output  COUNT_WIDTH  one-hot M-cycle of the executing instruction; all zero outside RUN.
o_Active  output  1  high in RUN only; gates microcode i_Active.
o_Force_Fetch  output  1  high during the FETCH state M-cycle; control unit performs the opcode fetch itself.
o_Halted  output  1  high in HALT.
o_M_Boundary  output  1  high on the clock that ends an M-cycle (step MSB set and i_Stall low).
o_Seq_Error  output  1  sticky; set on count overflow.

Behaviour:
- Clocking: one clock, i_Clk. Reset is synchronous and active-high on i_Reset.
- Reset values: step = 4'b0001, state = FETCH, count = 0, o_Active = 0, o_Force_Fetch = 1, o_Halted = 0, o_Seq_Error = 0, o_M_Boundary = 0. Reset wins over every other input, including mid-instruction and while i_Stall is high.
- Step counter: each clock with i_Stall low, the step rotates left: 0001 -> 0010 -> 0100 -> 1000 -> 0001. With i_Stall high, step, state, count and error all hold.
- Boundary: the clock where step[MSB] = 1 and i_Stall = 0. This clock pulses o_M_Boundary, which is combinational from registered step and i_Stall. i_IR_Fetch, i_Halt_Req and i_Wake are sampled only at a boundary; their values elsewhere are ignored.
- FETCH state: count = 0, o_Force_Fetch = 1. At the boundary, the state goes to RUN and count goes to 1 (LSB).
- RUN state: o_Active = 1. At the boundary, the first matching rule applies:
  - i_Halt_Req = 1: go to HALT, count = 0. Halt takes priority over i_IR_Fetch.
  - i_IR_Fetch = 1: count = 1.
  - count[MSB] = 1: count = 1 and o_Seq_Error is set (wrap-around).
  - Otherwise: count shifts left by one.
- HALT state: count = 0, o_Halted = 1, o_Active = 0, steps keep rotating. At a boundary with i_Wake = 1, go to FETCH.
- All outputs are registered or decoded from registered state, with no input-to-output paths except o_M_Boundary.
- count is always one-hot in RUN and zero otherwise.
- Latency: count changes on the clock after the boundary, together with step returning to 0001.

Test Plan:
- Reset then no stall: clocks 1-4 give FETCH with step 1, 2, 4, 8 and o_Force_Fetch = 1. Clock 5 gives RUN, count = 8'h01, step = 0001, o_Active = 1.
- 3-cycle instruction with i_IR_Fetch high only while count = 8'h04: count goes 01 -> 02 -> 04 -> 01, and o_M_Boundary pulses every 4 clocks.
- 2-cycle instruction with i_IR_Fetch high at count = 8'h02, then a stall of 3 clocks inside step 0100: step holds 3 clocks and the boundary is delayed 3 clocks. Then count = 8'h01.
- i_Halt_Req and i_IR_Fetch both high at a boundary: HALT, count = 0, o_Halted = 1. i_Wake pulsed at step 0010 is ignored. i_Wake held through the next boundary gives FETCH, then RUN with count = 8'h01.
- No i_IR_Fetch for 8 M-cycles from count = 8'h01: after count = 8'h80 the boundary wraps count to 8'h01, o_Seq_Error = 1, and it stays set until i_Reset.
- i_Reset asserted in RUN at count = 8'h08, step 0100, with i_Stall high: the next clock gives step 0001, FETCH, count 0, error 0.
